// File: rtl/cache_line_assembler.sv
// Collects 8 indexed burst beats into one cache line, aborting the burst on any ordering error.
// Latency: line_valid rises on the clock edge that accepts the 8th beat; seq_err follows the bad beat by 1 cycle.
// Backpressure: beat_ready drops while a line is held and returns the cycle after line_valid & line_ready (CACHE_LINE_ASM_WRAP_EN enables critical-word-first).
module cache_line_assembler #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          beat_valid,
  input  logic [IDX_W-1:0]              beat_idx,
  input  logic [WORD_W-1:0]             beat_data,
  input  logic                          beat_last,
  output logic                          beat_ready,
  output logic                          line_valid,
  output logic [WORD_W*(2**IDX_W)-1:0]  line_data,
  input  logic                          line_ready,
  output logic                          seq_err
);

  localparam int BEATS = 2**IDX_W;
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(BEATS-1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [IDX_W-1:0]                exp_idx;
  logic [IDX_W-1:0]                exp_idx_nxt;
  logic [IDX_W:0]                  beat_cnt;
  logic [IDX_W:0]                  beat_cnt_nxt;
  logic [BEATS-1:0][WORD_W-1:0]    line_buf;

  logic accept;
  logic final_beat;
  logic idx_ok;
  logic last_ok;
  logic beat_ok;

  assign line_data = line_buf;

  always_comb begin
    beat_ready   = (state == COLLECT);
    accept       = beat_valid & beat_ready;
    final_beat   = (beat_cnt == LAST_CNT);
`ifdef CACHE_LINE_ASM_WRAP_EN
    // Critical-word-first: the opening beat picks the starting slot.
    idx_ok       = (beat_cnt == '0) || (beat_idx == exp_idx);
`else
    idx_ok       = (beat_idx == exp_idx);
`endif
    last_ok      = (beat_last == final_beat);
    beat_ok      = idx_ok & last_ok;

    state_nxt    = state;
    exp_idx_nxt  = exp_idx;
    beat_cnt_nxt = beat_cnt;

    case (state)
      COLLECT: begin
        if (accept) begin
          if (beat_ok) begin
            exp_idx_nxt  = beat_idx + 1'b1;
            beat_cnt_nxt = beat_cnt + 1'b1;
            if (final_beat) begin
              state_nxt = HOLD;
            end
          end else begin
            exp_idx_nxt  = '0;
            beat_cnt_nxt = '0;
          end
        end
      end
      HOLD: begin
        if (line_ready) begin
          state_nxt    = COLLECT;
          exp_idx_nxt  = '0;
          beat_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = COLLECT;
        exp_idx_nxt  = '0;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= COLLECT;
      exp_idx  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      exp_idx  <= exp_idx_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // A rejected beat never touches the buffer; earlier slots of an aborted burst are simply overwritten later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_buf   <= '0;
      line_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      line_valid <= (state_nxt == HOLD);
      seq_err    <= accept & ~beat_ok;
      if (accept && beat_ok) begin
        line_buf[beat_idx] <= beat_data;
      end
    end
  end

endmodule
